issueq_freelist_ctrl: RTL and testbench

- Parametrised issue-queue free-entry reclaimer for the issue stage.
- Collects entries released by issue grants and by branch-mispredict squash into a pending vector.
- Presents up to FREE_PORTS reclaimed entries per cycle to the issue-queue free list over a valid/ready handshake.
- Successor to the fixed 64-entry, 4-port reclaimer. Adds generic depth and port counts, consumer back-pressure, a pending-count output and a full-flush mode.

---
 rtl/issueq_freelist_ctrl_pkg.sv | 20 ++
 rtl/issueq_freelist_ctrl_if.sv | 34 +++
 rtl/issueq_blk_prio_sel.sv | 21 ++
 rtl/issueq_freelist_ctrl.sv | 94 +++++++++
 tb/tb_issueq_freelist_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/issueq_freelist_ctrl_pkg.sv
// rtl/issueq_freelist_ctrl_pkg.sv - shared issue-queue reclaimer constants and slice helpers
package issueq_freelist_ctrl_pkg;

    localparam int unsigned IQ_ENTRIES     = 64;
    localparam int unsigned IQ_ENTRIES_LOG = 6;
    localparam int unsigned IQ_GRANT_PORTS = 4;
    localparam int unsigned IQ_FREE_PORTS  = 4;

    function automatic int unsigned blkSize(input int unsigned entries, input int unsigned ports);
        return entries / ports;
    endfunction

    localparam int unsigned IQ_BLK = blkSize(IQ_ENTRIES, IQ_FREE_PORTS);

    // Lowest bit of port `port` inside a packed per-port bus of `width`-bit fields.
    function automatic int unsigned portLsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/issueq_freelist_ctrl_if.sv
// rtl/issueq_freelist_ctrl_if.sv - grant/mispredict inputs and reclaim handshake bundle
interface issueq_freelist_ctrl_if
    import issueq_freelist_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES     = IQ_ENTRIES,
    parameter int unsigned ENTRIES_LOG = IQ_ENTRIES_LOG,
    parameter int unsigned GRANT_PORTS = IQ_GRANT_PORTS,
    parameter int unsigned FREE_PORTS  = IQ_FREE_PORTS
) ();

    logic                              ctrlMispredict_i;
    logic [ENTRIES-1:0]                mispredictVector_i;
    logic                              flush_i;
    logic [GRANT_PORTS*ENTRIES_LOG-1:0] grantedEntry_i;
    logic [GRANT_PORTS-1:0]            grantedValid_i;
    logic [FREE_PORTS*ENTRIES_LOG-1:0] freedEntry_o;
    logic [FREE_PORTS-1:0]             freedValid_o;
    logic [FREE_PORTS-1:0]             freedReady_i;
    logic [ENTRIES_LOG:0]              pendingCount_o;
    logic                              dupFree_o;

    modport slave (
        input  ctrlMispredict_i, mispredictVector_i, flush_i,
        input  grantedEntry_i, grantedValid_i, freedReady_i,
        output freedEntry_o, freedValid_o, pendingCount_o, dupFree_o
    );

    modport master (
        output ctrlMispredict_i, mispredictVector_i, flush_i,
        output grantedEntry_i, grantedValid_i, freedReady_i,
        input  freedEntry_o, freedValid_o, pendingCount_o, dupFree_o
    );

endinterface

// File: rtl/issueq_blk_prio_sel.sv
// rtl/issueq_blk_prio_sel.sv - BLK-wide lowest-set-bit selector
module issueq_blk_prio_sel #(
    parameter int unsigned BLK  = 16,
    parameter int unsigned OFFW = 4
) (
    input  logic [BLK-1:0]  reqVec,
    output logic            valid,
    output logic [OFFW-1:0] offset
);

    // Descending scan so the last hit written is the lowest index.
    always_comb begin
        offset = '0;
        for (int i = int'(BLK) - 1; i >= 0; i--) begin
            if (reqVec[i]) offset = OFFW'(i);
        end
    end

    assign valid = |reqVec;

endmodule

// File: rtl/issueq_freelist_ctrl.sv
// rtl/issueq_freelist_ctrl.sv - issue-queue free-entry reclaimer; optional ISSUEQ_FREELIST_DUPCHK_EN double-free check
module issueq_freelist_ctrl
    import issueq_freelist_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES     = IQ_ENTRIES,
    parameter int unsigned ENTRIES_LOG = IQ_ENTRIES_LOG,
    parameter int unsigned GRANT_PORTS = IQ_GRANT_PORTS,
    parameter int unsigned FREE_PORTS  = IQ_FREE_PORTS
) (
    input  logic                   clock,
    input  logic                   reset,
    issueq_freelist_ctrl_if.slave  bus
);

    localparam int unsigned BLK  = blkSize(ENTRIES, FREE_PORTS);
    localparam int unsigned OFFW = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int unsigned EL   = ENTRIES_LOG;

    logic [ENTRIES-1:0]       pendVec;
    logic [ENTRIES-1:0]       grantVec;
    logic [ENTRIES-1:0]       acceptVec;
    logic [ENTRIES-1:0]       nextVec;
    logic [EL:0]              pendingCount;
    logic [FREE_PORTS-1:0]    offerValid;
    logic [FREE_PORTS*EL-1:0] offerEntry;
    logic                     dupFree;

    function automatic logic [EL:0] popCount(input logic [ENTRIES-1:0] v);
        logic [EL:0] c;
        c = '0;
        for (int i = 0; i < int'(ENTRIES); i++) c = c + {{EL{1'b0}}, v[i]};
        return c;
    endfunction

    for (genvar p = 0; p < int'(FREE_PORTS); p++) begin : g_port
        logic [OFFW-1:0] offset;

        issueq_blk_prio_sel #(
            .BLK  (BLK),
            .OFFW (OFFW)
        ) u_sel (
            .reqVec (pendVec[portLsb(p, BLK) +: BLK]),
            .valid  (offerValid[p]),
            .offset (offset)
        );

        assign offerEntry[portLsb(p, EL) +: EL] =
            offerValid[p] ? (EL'(portLsb(p, BLK)) + EL'(offset)) : '0;
    end

    // Grant beats accept so a same-cycle release and re-grant keeps the entry pending.
    always_comb begin
        grantVec  = '0;
        acceptVec = '0;
        for (int g = 0; g < int'(GRANT_PORTS); g++) begin
            if (bus.grantedValid_i[g]) grantVec[bus.grantedEntry_i[portLsb(g, EL) +: EL]] = 1'b1;
        end
        for (int p = 0; p < int'(FREE_PORTS); p++) begin
            if (offerValid[p] && bus.freedReady_i[p]) acceptVec[offerEntry[portLsb(p, EL) +: EL]] = 1'b1;
        end
        nextVec = bus.flush_i ? '0 :
                  (grantVec | (~acceptVec & (pendVec |
                   ({ENTRIES{bus.ctrlMispredict_i}} & bus.mispredictVector_i))));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pendVec      <= '0;
            pendingCount <= '0;
        end else begin
            pendVec      <= nextVec;
            pendingCount <= popCount(nextVec);
        end
    end

`ifdef ISSUEQ_FREELIST_DUPCHK_EN
    logic dupHit;
    assign dupHit = (|(grantVec & pendVec & ~acceptVec)) ||
                    (bus.ctrlMispredict_i && (|(bus.mispredictVector_i & pendVec)));

    always_ff @(posedge clock) begin
        if (reset)       dupFree <= 1'b0;
        else if (dupHit) dupFree <= 1'b1;
    end
`else
    assign dupFree = 1'b0;
`endif

    assign bus.freedValid_o   = offerValid;
    assign bus.freedEntry_o   = offerEntry;
    assign bus.pendingCount_o = pendingCount;
    assign bus.dupFree_o      = dupFree;

endmodule

// File: tb/tb_issueq_freelist_ctrl.sv
// tb/tb_issueq_freelist_ctrl.sv - scoreboard bench for issueq_freelist_ctrl
module tb_issueq_freelist_ctrl;
    import issueq_freelist_ctrl_pkg::*;

    localparam int EN  = 64;
    localparam int EL  = 6;
    localparam int GP  = 4;
    localparam int FP  = 4;
    localparam int BLK = EN / FP;

    typedef struct {
        logic [FP-1:0]    valid;
        logic [FP*EL-1:0] entry;
        logic [EL:0]      count;
        logic             dup;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    issueq_freelist_ctrl_if #(.ENTRIES(EN), .ENTRIES_LOG(EL), .GRANT_PORTS(GP), .FREE_PORTS(FP)) bus ();

    issueq_freelist_ctrl #(.ENTRIES(EN), .ENTRIES_LOG(EL), .GRANT_PORTS(GP), .FREE_PORTS(FP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t          sbQ[$];
    logic [EN-1:0] mPend;
    logic          mDup;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t predict(input logic [EN-1:0] pend, input logic dup);
        exp_t e;
        e.valid = '0;
        e.entry = '0;
        for (int p = 0; p < FP; p++) begin
            for (int k = 0; k < BLK; k++) begin
                if (!e.valid[p] && pend[p*BLK+k]) begin
                    e.valid[p] = 1'b1;
                    e.entry[p*EL +: EL] = EL'(p*BLK + k);
                end
            end
        end
        e.count = (EL+1)'($countones(pend));
        e.dup = dup;
        return e;
    endfunction

    function automatic logic [GP*EL-1:0] packG(input int e0, input int e1, input int e2, input int e3);
        return {EL'(e3), EL'(e2), EL'(e1), EL'(e0)};
    endfunction

    task automatic stepCycle(input logic [GP*EL-1:0] ge, input logic [GP-1:0] gv, input logic misp,
                             input logic [EN-1:0] mv, input logic fl, input logic [FP-1:0] rdy);
        exp_t cur, got;
        logic [EN-1:0] gVec, aVec, mMask, nPend;
        bus.grantedEntry_i     = ge;
        bus.grantedValid_i     = gv;
        bus.ctrlMispredict_i   = misp;
        bus.mispredictVector_i = mv;
        bus.flush_i            = fl;
        bus.freedReady_i       = rdy;
        cur   = predict(mPend, mDup);
        gVec  = '0;
        aVec  = '0;
        for (int g = 0; g < GP; g++) if (gv[g]) gVec[ge[g*EL +: EL]] = 1'b1;
        for (int p = 0; p < FP; p++) if (cur.valid[p] && rdy[p]) aVec[cur.entry[p*EL +: EL]] = 1'b1;
        mMask = misp ? mv : '0;
`ifdef ISSUEQ_FREELIST_DUPCHK_EN
        if ((|(gVec & mPend & ~aVec)) || (|(mMask & mPend))) mDup = 1'b1;
`endif
        for (int i = 0; i < EN; i++) begin
            if (fl)           nPend[i] = 1'b0;
            else if (gVec[i]) nPend[i] = 1'b1;
            else if (aVec[i]) nPend[i] = 1'b0;
            else              nPend[i] = mPend[i] | mMask[i];
        end
        sbQ.push_back(predict(nPend, mDup));
        mPend = nPend;
        @(posedge clock);
        #1;
        if (sbQ.size() == 0) begin
            checkVal("sb_underflow", 64'd1, 64'd0);
        end else begin
            got = sbQ.pop_front();
            checkVal("valid", 64'(bus.freedValid_o), 64'(got.valid));
            for (int p = 0; p < FP; p++)
                checkVal($sformatf("entry%0d", p), 64'(bus.freedEntry_o[p*EL +: EL]), 64'(got.entry[p*EL +: EL]));
            checkVal("count", 64'(bus.pendingCount_o), 64'(got.count));
            checkVal("dup", 64'(bus.dupFree_o), 64'(got.dup));
        end
    endtask

    task automatic idle(input logic [FP-1:0] rdy);
        stepCycle('0, '0, 1'b0, '0, 1'b0, rdy);
    endtask

    task automatic doReset();
        bus.grantedEntry_i     = '0;
        bus.grantedValid_i     = '0;
        bus.ctrlMispredict_i   = 1'b0;
        bus.mispredictVector_i = '0;
        bus.flush_i            = 1'b0;
        bus.freedReady_i       = '0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mPend = '0;
        mDup  = 1'b0;
        sbQ.delete();
        checkVal("rst_valid", 64'(bus.freedValid_o), 64'd0);
        checkVal("rst_entry", 64'(bus.freedEntry_o), 64'd0);
        checkVal("rst_count", 64'(bus.pendingCount_o), 64'd0);
        checkVal("rst_dup", 64'(bus.dupFree_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic expDup;
        logic [GP*EL-1:0] ge;
        logic [EN-1:0] mv;
`ifdef ISSUEQ_FREELIST_DUPCHK_EN
        expDup = 1'b1;
`else
        expDup = 1'b0;
`endif
        doReset();

        // single grant, then accept
        stepCycle(packG(5, 0, 0, 0), 4'b0001, 1'b0, '0, 1'b0, 4'b0000);
        checkVal("tp1_valid0", 64'(bus.freedValid_o[0]), 64'd1);
        checkVal("tp1_entry0", 64'(bus.freedEntry_o[0 +: EL]), 64'd5);
        checkVal("tp1_count", 64'(bus.pendingCount_o), 64'd1);
        idle(4'b1111);
        checkVal("tp1_drained", 64'(bus.pendingCount_o), 64'd0);

        // one grant per block, all ports offer together
        stepCycle(packG(3, 20, 40, 60), 4'b1111, 1'b0, '0, 1'b0, 4'b1111);
        checkVal("tp2_valid", 64'(bus.freedValid_o), 64'hf);
        checkVal("tp2_entries", 64'(bus.freedEntry_o), 64'(packG(3, 20, 40, 60)));
        idle(4'b1111);
        checkVal("tp2_empty", 64'(bus.freedValid_o), 64'd0);
        checkVal("tp2_count", 64'(bus.pendingCount_o), 64'd0);

        // mispredict squash, held under back-pressure, then drains one per cycle
        stepCycle('0, '0, 1'b1, 64'h0000_0000_0000_0F00, 1'b0, 4'b0000);
        checkVal("tp3_entry", 64'(bus.freedEntry_o[0 +: EL]), 64'd8);
        checkVal("tp3_count", 64'(bus.pendingCount_o), 64'd4);
        idle(4'b0000);
        checkVal("tp3_hold", 64'(bus.freedEntry_o[0 +: EL]), 64'd8);
        for (int k = 9; k <= 11; k++) begin
            idle(4'b0001);
            checkVal("tp3_drain", 64'(bus.freedEntry_o[0 +: EL]), 64'(k));
        end
        idle(4'b0001);
        checkVal("tp3_done", 64'(bus.pendingCount_o), 64'd0);

        // flush overrides same-cycle grants
        stepCycle(packG(7, 0, 0, 0), 4'b0001, 1'b0, '0, 1'b0, 4'b0000);
        stepCycle(packG(1, 2, 0, 0), 4'b0011, 1'b0, '0, 1'b1, 4'b0000);
        checkVal("tp4_valid", 64'(bus.freedValid_o), 64'd0);
        checkVal("tp4_count", 64'(bus.pendingCount_o), 64'd0);

        // accept and re-grant of the same entry keeps it pending
        stepCycle(packG(17, 0, 0, 0), 4'b0001, 1'b0, '0, 1'b0, 4'b0000);
        stepCycle(packG(0, 17, 0, 0), 4'b0010, 1'b0, '0, 1'b0, 4'b0010);
        checkVal("tp5_valid1", 64'(bus.freedValid_o[1]), 64'd1);
        checkVal("tp5_entry1", 64'(bus.freedEntry_o[EL +: EL]), 64'd17);
        checkVal("tp5_count", 64'(bus.pendingCount_o), 64'd1);
        idle(4'b1111);

        // double free: sticky through flush, cleared by reset
        stepCycle(packG(30, 0, 0, 0), 4'b0001, 1'b0, '0, 1'b0, 4'b0000);
        checkVal("dup_first", 64'(bus.dupFree_o), 64'd0);
        stepCycle(packG(30, 0, 0, 0), 4'b0001, 1'b0, '0, 1'b0, 4'b0000);
        checkVal("dup_second", 64'(bus.dupFree_o), 64'(expDup));
        stepCycle('0, '0, 1'b0, '0, 1'b1, 4'b0000);
        checkVal("dup_flush", 64'(bus.dupFree_o), 64'(expDup));
        doReset();

        // randomised traffic checked through the scoreboard, with one reset mid-stream
        for (int n = 0; n < 300; n++) begin
            if (n == 150) doReset();
            ge = '0;
            for (int g = 0; g < GP; g++) ge[g*EL +: EL] = EL'($urandom_range(0, EN-1));
            mv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            stepCycle(ge, GP'($urandom), ($urandom_range(0, 7) == 0), mv,
                      ($urandom_range(0, 39) == 0), FP'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
